// File: rtl/axil_reg_responder_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
// Optional feature macro used by the design: AXIL_SLVERR_EN.
package axil_reg_pkg;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the
// register responder (slave).
interface axil_reg_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axil_reg_responder_bank.sv
// Register storage for the AXI4-Lite responder: one byte-strobed write
// port, one combinational read port, and a flat view of every register.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [31:0]              i_wr_data,
  input  logic [3:0]               i_wr_strb,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic [31:0]              o_rd_data,
  output logic [NUM_REGS*32-1:0]   o_regs
);

  logic [31:0] r_regs [NUM_REGS];

  // Commit a strobed write into the addressed register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_idx] <= strb_merge(r_regs[i_wr_idx], i_wr_data, i_wr_strb);
    end
  end

  // Read port sees pre-edge contents, so a same-cycle write is not visible.
  assign o_rd_data = r_regs[i_rd_idx];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[32*k +: 32] = r_regs[k];
  end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder: NUM_REGS 32-bit control registers with
// independent write (AW/W/B) and read (AR/R) state machines.
// Optional macro AXIL_SLVERR_EN: out-of-range addresses get SLVERR, writes
// to them are dropped and reads return zero; otherwise addresses alias.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axil_reg_responder_if.slave    s_axi,
  output logic [NUM_REGS*32-1:0] reg_out
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
`ifdef AXIL_SLVERR_EN
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
`endif

  // ---------------- write channel ----------------
  wr_state_e               r_wr_state;
  wr_state_e               w_wr_state_nxt;
  logic                    r_aw_held;
  logic                    r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic [1:0]              r_bresp;

  logic                    w_awready;
  logic                    w_wready;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_wr_commit;
  logic                    w_wr_err;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [STRB_W-1:0]       w_wr_strb;

  assign w_awready = (r_wr_state == WR_IDLE) && !r_aw_held && !ARESET;
  assign w_wready  = (r_wr_state == WR_IDLE) && !r_w_held  && !ARESET;
  assign w_aw_hs   = s_axi.S_AXI_AWVALID && w_awready;
  assign w_w_hs    = s_axi.S_AXI_WVALID  && w_wready;

  // A channel that completes in the commit cycle bypasses its holding register.
  assign w_wr_addr = r_aw_held ? r_awaddr : s_axi.S_AXI_AWADDR;
  assign w_wr_data = r_w_held  ? r_wdata  : s_axi.S_AXI_WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi.S_AXI_WSTRB;

`ifdef AXIL_SLVERR_EN
  assign w_wr_err = (32'(w_wr_addr) >= SPAN);
`else
  assign w_wr_err = 1'b0;
`endif

  // Write FSM next state: commit once both address and data are available.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_commit    = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_wr_commit    = 1'b1;
          w_wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wr_state <= WR_IDLE;
    else        r_wr_state <= w_wr_state_nxt;
  end

  // Held flags and write response; flags clear on commit and on reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_wr_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_w_hs)  r_w_held  <= 1'b1;
    end
  end

  // Capture address/data payloads on their handshakes; qualified by the held flags.
  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_awaddr <= s_axi.S_AXI_AWADDR;
    if (w_w_hs) begin
      r_wdata <= s_axi.S_AXI_WDATA;
      r_wstrb <= s_axi.S_AXI_WSTRB;
    end
  end

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = (r_wr_state == WR_RESP);
  assign s_axi.S_AXI_BRESP   = r_bresp;

  // ---------------- read channel ----------------
  rd_state_e               r_rd_state;
  rd_state_e               w_rd_state_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    w_arready;
  logic                    w_ar_hs;
  logic                    w_rd_err;
  logic [31:0]             w_bank_rdata;

  assign w_arready = (r_rd_state == RD_IDLE) && !ARESET;
  assign w_ar_hs   = s_axi.S_AXI_ARVALID && w_arready;

`ifdef AXIL_SLVERR_EN
  assign w_rd_err = (32'(s_axi.S_AXI_ARADDR) >= SPAN);
`else
  assign w_rd_err = 1'b0;
`endif

  // Read FSM next state: one response per accepted address.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_state_nxt = RD_RESP;
      RD_RESP: if (s_axi.S_AXI_RREADY) w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_state_nxt;
  end

  // Register read data/response on AR handshake and hold until the R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_err ? '0 : w_bank_rdata;
      r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = (r_rd_state == RD_RESP);
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  // ---------------- storage ----------------
  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_wr_en   (w_wr_commit && !w_wr_err),
    .i_wr_idx  (w_wr_addr[IDX_W+1:2]),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb),
    .i_rd_idx  (s_axi.S_AXI_ARADDR[IDX_W+1:2]),
    .o_rd_data (w_bank_rdata),
    .o_regs    (reg_out)
  );

  // Protection bits and address bits outside the decoded index are don't-care.
  logic w_unused;
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      w_wr_addr, s_axi.S_AXI_ARADDR};

endmodule
